// File: rtl/dose_scheduler.sv
// Dose scheduler: programmable dose-time slots feeding per-channel request
// queues, served one channel at a time by a shared motor pulse engine with
// round-robin arbitration, inter-pulse gap and a timed dispense alarm.
module dose_scheduler #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned NUM_SLOTS     = 3,
  parameter int unsigned PULSE_CYCLES  = 10000000,
  parameter int unsigned GAP_CYCLES    = 1000,
  parameter int unsigned ALARM_SECONDS = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              secondP,
  input  logic [4:0]        hours,
  input  logic [5:0]        minutes,
  input  logic [5:0]        seconds,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_slot,
  input  logic              cfg_en,
  input  logic [4:0]        cfg_hour,
  input  logic [5:0]        cfg_min,
  input  logic [NUM_CH-1:0] cfg_mask,
  input  logic [NUM_CH-1:0] override,
  input  logic              alarm_ack,
  output logic [NUM_CH-1:0] dispense,
  output logic              busy,
  output logic [NUM_CH-1:0] pending,
  output logic              alarm,
  output logic [7:0]        missed
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned HOLD_W  = (ALARM_SECONDS > 0) ? $clog2(ALARM_SECONDS + 1) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  typedef struct packed {
    logic              en;
    logic [4:0]        hour;
    logic [5:0]        min;
    logic [NUM_CH-1:0] mask;
  } slot_t;

  slot_t             slot_q [NUM_SLOTS];
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0] ovr_q;

  logic [NUM_CH-1:0] sched_req, req, drop, grant_clr;
  logic [NUM_CH-1:0] dispense_d, pending_d;
  logic              busy_d, alarm_d, found;
  logic [CH_W-1:0]   cand, pick;
  logic [7:0]        missed_d;

  // Slot configuration storage with fixed power-up schedule.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_q[s].en   <= (s < 3);
        slot_q[s].hour <= (s == 0) ? 5'd8 : (s == 1) ? 5'd13 : (s == 2) ? 5'd20 : 5'd0;
        slot_q[s].min  <= '0;
        slot_q[s].mask <= '1;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (cfg_we && (cfg_slot == 3'(s))) begin
          slot_q[s] <= slot_t'({cfg_en, cfg_hour, cfg_min, cfg_mask});
        end
      end
    end
  end

  // Request vector: schedule matches plus override rising edges; busy channels drop.
  always_comb begin
    sched_req = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (secondP && (seconds == 6'd0) && slot_q[s].en &&
          (slot_q[s].hour == hours) && (slot_q[s].min == minutes)) begin
        sched_req = sched_req | slot_q[s].mask;
      end
    end
    req  = sched_req | (override & ~ovr_q);
    drop = req & (pending | dispense);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      hold_q   <= '0;
      ovr_q    <= '0;
      dispense <= '0;
      busy     <= 1'b0;
      pending  <= '0;
      alarm    <= 1'b0;
      missed   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      ovr_q    <= override;
      dispense <= dispense_d;
      busy     <= busy_d;
      pending  <= pending_d;
      alarm    <= alarm_d;
      missed   <= missed_d;
    end
  end

  // Pulse engine next-state, arbitration, alarm hold and queue update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    hold_d     = hold_q;
    dispense_d = dispense;
    alarm_d    = alarm;
    grant_clr  = '0;
    found      = 1'b0;
    cand       = '0;
    pick       = '0;

    case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          cand = CH_W'((32'(rr_q) + 32'(i)) % NUM_CH);
          if (!found && pending[cand]) begin
            found = 1'b1;
            pick  = cand;
          end
        end
        if (found) begin
          grant_clr[pick]  = 1'b1;
          dispense_d       = '0;
          dispense_d[pick] = 1'b1;
          gnt_d            = pick;
          cnt_d            = CNT_W'(PULSE_CYCLES - 1);
          state_d          = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          dispense_d = '0;
          rr_d       = (32'(gnt_q) == NUM_CH - 1) ? '0 : gnt_q + CH_W'(1);
          cnt_d      = CNT_W'(GAP_CYCLES - 1);
          hold_d     = HOLD_W'(ALARM_SECONDS);
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Alarm hold counts seconds only outside a pulse; a new pulse wins over ack.
    if (secondP && (state_q != PULSE) && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
      if (hold_q == HOLD_W'(1)) alarm_d = 1'b0;
    end
    if (alarm_ack) alarm_d = 1'b0;
    if (found)     alarm_d = 1'b1;

    pending_d = (pending & ~grant_clr) | (req & ~drop);
    missed_d  = ((|drop) && (missed != 8'hFF)) ? missed + 8'd1 : missed;
    busy_d    = (state_d != IDLE);
  end

endmodule

// File: doc/dose_scheduler.md
Name: dose_scheduler

Overview:
Parametrised successor to the fixed morning/afternoon/evening dispense path. It holds NUM_SLOTS programmable dose times and a per-slot channel mask, and queues dose requests per channel from schedule matches and manual override. A single shared pulse engine drives NUM_CH motor outputs one at a time, with round-robin arbitration and an inter-pulse gap, and raises an alarm that holds for a set number of seconds. It sits between the time-of-day counter and the GPIO motor ports.

Parameters:
NUM_CH, 4, number of dispenser channels/motor outputs (1..8)
NUM_SLOTS, 3, number of programmable dose-time slots (1..8)
PULSE_CYCLES, 10000000, clock cycles one motor output is held high per dose
GAP_CYCLES, 1000, idle clock cycles between consecutive pulses
ALARM_SECONDS, 5, secondP ticks the alarm holds after the last pulse ends

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
secondP  in  1  one-cycle pulse once per second; time inputs are valid on this cycle
hours  in  5  current hour, 0..23
minutes  in  6  current minute, 0..59
seconds  in  6  current second, 0..59
cfg_we  in  1  one-cycle write strobe for slot configuration
cfg_slot  in  3  slot index to write; writes with index >= NUM_SLOTS are ignored
cfg_en  in  1  slot enable
cfg_hour  in  5  slot hour
cfg_min  in  6  slot minute
cfg_mask  in  NUM_CH  channels served by the slot
override  in  NUM_CH  manual dispense request per channel, level; rising edge is used
alarm_ack  in  1  clears the alarm
dispense  out  NUM_CH  motor drive, one-hot or zero
busy  out  1  pulse engine is not IDLE
pending  out  NUM_CH  queued requests
alarm  out  1  dispense alarm
missed  out  8  saturating count of requests dropped because the channel was already pending

Behaviour:
- Reset (async, resetn=0): dispense=0, busy=0, pending=0, alarm=0, missed=0, FSM=IDLE, round-robin pointer=0, override edge registers=0.
- Slot reset values:
  - slot0: 08:00, enabled.
  - slot1: 13:00, enabled.
  - slot2: 20:00, enabled.
  - Slots 3 and above: 00:00, disabled.
  - All slot masks are all-ones.
- cfg_we writes {en, hour, min, mask} to the selected slot on that edge. A write is visible to a match starting the next cycle.
- Slot match:
  - Condition: secondP=1 && seconds==0 && hours==slot_hour && minutes==slot_min && slot enabled.
  - Request vector for the cycle = OR over matching slots' masks, OR'd with the override rising edges.
  - Requests arriving on a channel already pending, or currently pulsing, are dropped and increment missed (saturating at 255). Multiple such drops in one cycle add 1.
  - Otherwise the request sets the pending bit the next cycle.
- Pulse engine FSM:
  - IDLE: if pending!=0, grant the first pending channel at or after the RR pointer (wrapping). Clear its pending bit, set its dispense bit, load the counter, go to PULSE.
  - PULSE: dispense held for exactly PULSE_CYCLES cycles, then dispense=0, RR pointer = granted+1 mod NUM_CH, go to GAP.
  - GAP: GAP_CYCLES cycles with dispense=0, then go to IDLE. A new grant is possible on the next IDLE cycle.
  - Latency: a request on cycle t is pending at t+1 and dispensing from t+2 when the engine is IDLE.
- At most one dispense bit is ever high.
- Alarm:
  - Set on every transition into PULSE.
  - Hold counter reloads to ALARM_SECONDS when PULSE ends; it decrements on secondP only while FSM is IDLE or GAP.
  - Alarm clears when the counter reaches 0, or on alarm_ack.
  - Set has priority over ack in the same cycle.
- Counters are sized with clog2 of their parameter. Hours/minutes are compared at full width, with no wrap arithmetic.
- Reset mid-pulse drops dispense immediately and discards all pending requests.

Test Plan:
- Reset, then set hours=8, minutes=0, seconds=0 with secondP -> pending=4'b1111 next cycle. Channels then pulse in order 0,1,2,3, each PULSE_CYCLES high separated by GAP_CYCLES (use small parameters: PULSE=20, GAP=4).
- Write slot1 = 09:30, mask 4'b0100. Apply 09:30:00 tick -> only dispense[2] pulses. The 13:00:00 tick then does nothing for slot1.
- Assert override[1] while channel 1 is pulsing from a schedule -> missed=1, no second pulse. Re-assert after the pulse ends -> channel 1 pulses again.
- After channel 3 is granted, with pending={0,1} -> the next grant is channel 0, then channel 1 (round-robin wrap).
- Alarm with ALARM_SECONDS=5 -> alarm high at pulse start, low after the 5th secondP past pulse end. alarm_ack mid-hold clears it at once. A new pulse re-asserts it.
- Drop resetn mid-PULSE -> dispense=0, pending=0, alarm=0 asynchronously. No pulse resumes after release.
